dvs_event_fifo: RTL
===================

# dvs_event_fifo

Event buffer directly downstream of the DVS AER-to-event interface. Arbitrates the single-requester FIFO bus with a `fifo_req`/`fifo_grant` handshake and captures the preprocessed event the producer drives onto `fifo_bus_event` one cycle after grant. Stores events in a circular buffer and presents them first-word-fall-through to the RAVENS-side consumer.

## Interface
- `EVENT_BITS`, default `dvs_ravens_pkg::EVENT_BITS`: width of one stored event.
- `DEPTH`, default 16: number of entries; power of two, ≥ 2.
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `fifo_req` input 1: producer has an unwritten, unfiltered event.
- `fifo_bus_event` input EVENT_BITS: event bus; valid only in the cycle after `fifo_grant` is high, otherwise may be Z.
- `fifo_grant` output 1: registered one-cycle grant pulse to the producer.
- `rd_en` input 1: consumer pops the head entry.
- `rd_data` output EVENT_BITS: head entry, valid while `empty` = 0.
- `empty` output 1: no stored entries.
- `full` output 1: DEPTH entries stored.
- `count` output $clog2(DEPTH)+1: stored entries, 0..DEPTH.
- `underflow` output 1: sticky; set by `rd_en` while `empty`.

## Operation
- Write FSM, three states:
  - IDLE: `fifo_grant`=0. Go to GRANT when `fifo_req`=1 and `count` < DEPTH. Stay otherwise.
  - GRANT: `fifo_grant`=1 for exactly one cycle. Always go to CAPTURE.
  - CAPTURE: `fifo_grant`=0. Sample `fifo_bus_event` into `mem[wr_ptr]`, increment `wr_ptr`. Always go to IDLE.
- Free-space check in IDLE uses `count` as it will stand after any pop in the same cycle. Only one write is ever in flight, so the check guarantees no overflow and needs no reservation.
- `fifo_req` is not re-sampled in GRANT or CAPTURE. The producer drops it after the grant, and it is next evaluated in IDLE.
- Read path: `rd_data` = `mem[rd_ptr]` combinationally (FWFT). `rd_en` with `empty`=0 increments `rd_ptr`. `rd_en` with `empty`=1 is ignored and sets `underflow`.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- `count` +1 on CAPTURE write, −1 on valid pop, unchanged when both occur in the same cycle.
- `empty` = (`count`==0), `full` = (`count`==DEPTH), both registered through `count`.
- Bus value outside CAPTURE is never sampled, so Z/X on the bus has no effect.

## Timing
- Reset values: state IDLE, `fifo_grant` 0, `wr_ptr`/`rd_ptr`/`count` 0, `empty` 1, `full` 0, `underflow` 0, `rd_data` reads `mem[0]` (memory not reset; treat as don't-care while `empty`).
- Handshake latency, with `fifo_req` high in cycle 0 and FIFO not full:
  - Cycle 1: `fifo_grant`=1.
  - Cycle 2: bus valid; written at the end of cycle 2.
  - Cycle 3: `count` +1, `empty`=0, `rd_data` shows the event.
- Maximum write rate: one event per 3 cycles.
- Full: no grant is issued and `fifo_req` is held by the producer. A grant follows on the cycle after the pop that frees space (pop and IDLE check in the same cycle → grant the next cycle).
- Reset asserted mid-handshake: FSM returns to IDLE at that edge, `fifo_grant` drops, and the in-flight event is discarded. The producer re-requests after its own reset.

## Configuration
- `DVS_FIFO_STALL_CNT_EN`: when defined, adds output `stall_count` (16 bits, reset 0, saturating at 0xFFFF). It increments each cycle that state is IDLE, `fifo_req`=1 and `count`==DEPTH, and it clears only on `rst`.
- When the macro is undefined, the port and its logic are absent and behaviour is otherwise identical.

## Test plan
- Single event: `fifo_req` high in cycle 0, bus=0x1A5 in cycle 2 → `fifo_grant` high only in cycle 1; cycle 3: `empty`=0, `count`=1, `rd_data`=0x1A5.
- Fill to full: DEPTH=16, back-to-back requests → 16 grants 3 cycles apart, then `full`=1, no 17th grant. With the macro enabled, `stall_count` counts the held-request cycles.
- Pop while full: `rd_en` in cycle N → grant in cycle N+1, `count` returns to 16 at N+3, and data order is preserved across pointer wrap.
- Simultaneous pop and CAPTURE with `count`=5 → `count` stays 5, and the head advances to the next entry.
- `rd_en` while empty → `count` stays 0, pointers unchanged, `underflow`=1 and sticky until `rst`.
- `rst` asserted during GRANT → next cycle `fifo_grant`=0, `count`=0, `empty`=1, and the bus value in the following cycle is not stored.

Source files
------------

// File: rtl/dvs_ravens_pkg.sv
// Shared constants for the DVS-to-RAVENS event path.
// EVENT_BITS is the width of one preprocessed event word.
package dvs_ravens_pkg;
  localparam int EVENT_BITS = 12;
endpackage

// File: rtl/dvs_event_fifo_if.sv
// Producer grant bus and FWFT consumer port of the DVS event FIFO.
// Optional stall_count member exists when DVS_FIFO_STALL_CNT_EN is defined.
interface dvs_event_fifo_if #(
  parameter int W     = dvs_ravens_pkg::EVENT_BITS,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          fifo_req;
  logic [W-1:0]  fifo_bus_event;
  logic          fifo_grant;
  logic          rd_en;
  logic [W-1:0]  rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          underflow;
`ifdef DVS_FIFO_STALL_CNT_EN
  logic [15:0]   stall_count;

  modport slave (
    input  fifo_req, fifo_bus_event, rd_en,
    output fifo_grant, rd_data, empty,
    output full, count, underflow,
    output stall_count
  );
  modport master (
    output fifo_req, fifo_bus_event, rd_en,
    input  fifo_grant, rd_data, empty,
    input  full, count, underflow,
    input  stall_count
  );
`else
  modport slave (
    input  fifo_req, fifo_bus_event, rd_en,
    output fifo_grant, rd_data, empty,
    output full, count, underflow
  );
  modport master (
    output fifo_req, fifo_bus_event, rd_en,
    input  fifo_grant, rd_data, empty,
    input  full, count, underflow
  );
`endif
endinterface

// File: rtl/dvs_event_fifo.sv
// Granted-bus event FIFO with FWFT read side (DVS -> RAVENS).
// Define DVS_FIFO_STALL_CNT_EN to add the saturating stall_count output.
module dvs_event_fifo #(
  parameter int EVENT_BITS = dvs_ravens_pkg::EVENT_BITS,
  parameter int DEPTH      = 16
) (
  input  logic clk,
  input  logic rst,
  dvs_event_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    CAPTURE
  } state_e;

  state_e state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] count_after_pop;
  logic underflow_q, underflow_d;
  logic pop, wr;
  logic [EVENT_BITS-1:0] mem_q [DEPTH];

  always_comb begin
    pop = bus.rd_en && (count_q != '0);
    wr = (state_q == CAPTURE);
    // Free-space check sees this cycle's pop
    count_after_pop = count_q - CW'(pop);
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.fifo_req && (count_after_pop < FULL_CNT))
          state_d = GRANT;
      end
      GRANT: state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    wr_ptr_d = wr_ptr_q + AW'(wr);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d = count_q;
    if (wr && !pop)
      count_d = count_q + CW'(1);
    else if (!wr && pop)
      count_d = count_q - CW'(1);
    underflow_d = underflow_q
      | (bus.rd_en && (count_q == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr)
      mem_q[wr_ptr_q] <= bus.fifo_bus_event;
  end

  assign bus.fifo_grant = (state_q == GRANT);
  assign bus.rd_data    = mem_q[rd_ptr_q];
  assign bus.empty      = (count_q == '0);
  assign bus.full       = (count_q == FULL_CNT);
  assign bus.count      = count_q;
  assign bus.underflow  = underflow_q;

`ifdef DVS_FIFO_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && bus.fifo_req
        && (count_q == FULL_CNT)
        && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= '0;
    else
      stall_q <= stall_d;
  end

  assign bus.stall_count = stall_q;
`endif
endmodule
